branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised branch prediction and resolution unit for the 32-bit core. It replaces the combinational PC-source selector with a direct-mapped branch target buffer (BTB) of 2-bit saturating counters, which the IF stage reads to predict. It resolves branches and jumps in EX against that prediction, and drives a redirect and a multi-cycle flush on mispredict. It keeps the existing 2-bit PC-source encoding so the PC mux is unchanged.

## Interface
- XLEN, 32, address/data width
- ENTRIES, 64, BTB entries; power of two, ≥2; IDX = log2(ENTRIES)
- TAG_W, 8, tag bits stored per entry
- FLUSH_CYC, 2, cycles flush is held after a mispredict; ≥1
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- if_pc  in  XLEN  fetch PC
- pred_taken  out  1  prediction for if_pc
- pred_target  out  XLEN  predicted target; if_pc+4 when pred_taken=0
- ex_valid  in  1  EX holds a real instruction
- ex_pc  in  XLEN  PC of EX instruction
- ex_kind  in  2  00 JR, 01 J/JAL, 10 BEQ/BNE, 11 non-branch
- ex_cond  in  XLEN  ALU result; nonzero means a conditional branch is taken
- ex_target  in  XLEN  computed target
- ex_pred_taken  in  1  prediction carried down the pipe
- ex_pred_target  in  XLEN  predicted target carried down the pipe
- mispredict  out  1  one-cycle pulse, combinational from EX
- redirect_pc  out  XLEN  correct next PC, valid when mispredict=1
- pc_src  out  2  00 JR, 01 J, 10 taken cond, 11 sequential/predicted
- flush  out  1  registered; squash IF/ID
- br_count, mp_count  out  32  resolved-branch and mispredict counters; wrap at 2^32

## Operation
- Index = pc[IDX+1:2]. Tag = pc[IDX+TAG_W+1:IDX+2]. Entry fields: valid, tag, kind, ctr[1:0], target.
- Lookup is combinational. hit = valid & tag match. pred_taken = hit & (kind≠10 | ctr[1]).
- Resolution: taken = 1 for kind 00/01, (ex_cond≠0) for kind 10, 0 for kind 11. Correct PC = taken ? ex_target : ex_pc+4.
- live = ex_valid & state==IDLE. mispredict = live & ((taken≠ex_pred_taken) | (taken & ex_target≠ex_pred_target)).
- pc_src = 11 unless mispredict. On mispredict: taken → 00/01/10 by kind; not-taken → 11 with redirect_pc = ex_pc+4.
- Update happens at the clock edge when live, using the EX index and tag:
  - kind≠11 and hit: set ctr +1 saturating at 11 if taken, −1 saturating at 00 if not. Write target if taken.
  - kind≠11 and miss: allocate only if taken, with valid=1, ctr=10, and the new tag/kind/target.
  - kind=11 and hit: clear valid, to remove the alias.
- br_count increments on live & kind≠11. mp_count increments on mispredict.
- FSM:
  - IDLE → FLUSH on mispredict, loading cnt=FLUSH_CYC−1.
  - FLUSH: flush=1. Decrement cnt; → IDLE when cnt==0.
  - In FLUSH, EX inputs are ignored: no update, no count, no mispredict.

## Timing
- Prediction has 0-cycle latency from if_pc. mispredict, redirect_pc and pc_src have 0-cycle latency from EX inputs.
- flush rises the cycle after mispredict and stays high exactly FLUSH_CYC cycles.
- Simultaneous lookup and update of the same index: the lookup returns the pre-update value. The write is visible next cycle.
- Reset, asynchronous and taking effect mid-flush as well:
  - all valid=0, all ctr=01
  - state=IDLE, flush=0, counters=0
  - pc_src=11, mispredict=0
  - while reset=1, outputs hold these values regardless of inputs.

## Test plan
- Reset then lookup pc 0x100 → pred_taken=0, pred_target=0x104. EX BEQ at 0x100, target 0x200, cond=1, pred 0 → mispredict=1, pc_src=10, redirect 0x200. flush high 2 cycles. The next lookup of 0x100 predicts taken, target 0x200.
- Same BEQ resolved not-taken 2× after allocation → ctr 10→01→00, prediction becomes 0. The second resolution mispredicts with redirect 0x104.
- JR at 0x40: first to 0x500, then to 0x600 with predicted 0x500 → mispredict, pc_src=00, redirect 0x600. The entry target updates to 0x600.
- Alias: kind=11 instruction at an indexed/tagged PC with ex_pred_taken=1 → mispredict, pc_src=11, redirect pc+4. The entry is invalidated.
- Second mispredict during FLUSH is ignored: no counter change, no table write. Assert reset in FLUSH cycle 1 → flush=0 immediately, and the table is cleared.
- ENTRIES=4: PCs 0x10 and 0x20, with the same index and different tags, evict each other. br_count/mp_count match the scoreboard over 1000 random branches.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters for IF-stage prediction,
// plus EX-stage branch resolution, redirect and a fixed-length flush on mispredict.
module branch_predictor #(
    parameter int XLEN      = 32,
    parameter int ENTRIES   = 64,
    parameter int TAG_W     = 8,
    parameter int FLUSH_CYC = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [1:0]      ex_kind,
    input  logic [XLEN-1:0] ex_cond,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [1:0]      pc_src,
    output logic            flush,
    output logic [31:0]     br_count,
    output logic [31:0]     mp_count,
    output logic            dbg_state
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYC - 1);

    localparam logic [1:0] K_JR = 2'b00;
    localparam logic [1:0] K_J  = 2'b01;
    localparam logic [1:0] K_BR = 2'b10;
    localparam logic [1:0] K_NB = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         br_count_q, mp_count_q;

    logic [ENTRIES-1:0]  valid_q;
    logic [1:0]          ctr_q    [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [1:0]          kind_q   [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];

    logic [IDX-1:0]      if_idx, ex_idx;
    logic [TAG_W-1:0]    if_tag, ex_tag;
    logic                if_hit, ex_hit;
    logic                live, ex_taken;
    logic [XLEN-1:0]     ex_seq_pc;
    logic [1:0]          ctr_cur, ctr_d;
    logic                do_alloc, do_upd, do_inval;

    // Fetch-side lookup
    assign if_idx      = if_pc[IDX+1:2];
    assign if_tag      = if_pc[IDX+TAG_W+1:IDX+2];
    assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken  = if_hit && ((kind_q[if_idx] != K_BR) || ctr_q[if_idx][1]);
    assign pred_target = pred_taken ? target_q[if_idx] : (if_pc + XLEN'(4));

    // Execute-side resolution; reset gating keeps outputs quiet while reset is held
    assign ex_idx    = ex_pc[IDX+1:2];
    assign ex_tag    = ex_pc[IDX+TAG_W+1:IDX+2];
    assign ex_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign live      = ex_valid && (state_q == ST_IDLE) && !reset;
    assign ex_seq_pc = ex_pc + XLEN'(4);

    always_comb begin
        ex_taken = 1'b0;
        case (ex_kind)
            K_JR, K_J: ex_taken = 1'b1;
            K_BR:      ex_taken = (ex_cond != '0);
            default:   ex_taken = 1'b0;
        endcase
    end

    assign mispredict  = live && ((ex_taken != ex_pred_taken) ||
                                  (ex_taken && (ex_target != ex_pred_target)));
    assign redirect_pc = ex_taken ? ex_target : ex_seq_pc;
    assign pc_src      = (mispredict && ex_taken) ? ex_kind : K_NB;

    always_comb begin
        ctr_cur = ctr_q[ex_idx];
        ctr_d   = ctr_cur;
        if (ex_taken) begin
            if (ctr_cur != 2'b11) ctr_d = ctr_cur + 2'b01;
        end else begin
            if (ctr_cur != 2'b00) ctr_d = ctr_cur - 2'b01;
        end
    end

    assign do_alloc = live && (ex_kind != K_NB) && !ex_hit && ex_taken;
    assign do_upd   = live && (ex_kind != K_NB) && ex_hit;
    assign do_inval = live && (ex_kind == K_NB) && ex_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
        end else if (do_alloc) begin
            valid_q[ex_idx] <= 1'b1;
            ctr_q[ex_idx]   <= 2'b10;
        end else if (do_upd) begin
            ctr_q[ex_idx]   <= ctr_d;
        end else if (do_inval) begin
            valid_q[ex_idx] <= 1'b0;
        end
    end

    // Payload fields are qualified by valid_q, so they need no reset
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            tag_q[ex_idx]    <= ex_tag;
            kind_q[ex_idx]   <= ex_kind;
            target_q[ex_idx] <= ex_target;
        end else if (do_upd && ex_taken) begin
            target_q[ex_idx] <= ex_target;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (mispredict) begin
                    state_d = ST_FLUSH;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            br_count_q <= '0;
            mp_count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (live && (ex_kind != K_NB)) br_count_q <= br_count_q + 32'd1;
            if (mispredict)                mp_count_q <= mp_count_q + 32'd1;
        end
    end

    assign flush     = (state_q == ST_FLUSH);
    assign br_count  = br_count_q;
    assign mp_count  = mp_count_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed and random bench for branch_predictor (ENTRIES=4 so aliasing is easy to reach).
module tb_branch_predictor;

    localparam int EW = 4 + 1 + 32 + 1 + 32 + 2 + 1 + 32 + 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [1:0]  ex_kind;
    logic [31:0] ex_cond;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [1:0]  pc_src;
    logic        flush;
    logic [31:0] br_count;
    logic [31:0] mp_count;
    logic        dbg_state;

    branch_predictor #(
        .XLEN(32), .ENTRIES(4), .TAG_W(8), .FLUSH_CYC(2)
    ) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_kind(ex_kind), .ex_cond(ex_cond),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .pc_src(pc_src),
        .flush(flush), .br_count(br_count), .mp_count(mp_count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Scoreboard: one packed expectation per cycle, popped by the monitor at negedge
    logic [EW-1:0] exp_q[$];
    int            id_q[$];
    int            checks = 0;
    int            errors = 0;
    int            step_id = 0;

    logic [3:0]  e_mask;
    logic        e_pt;
    logic [31:0] e_ptg;
    logic        e_mp;
    logic [31:0] e_rd;
    logic [1:0]  e_src;
    logic        e_fl;
    logic [31:0] e_br;
    logic [31:0] e_mpc;

    task automatic set_ex(input logic v, input logic [31:0] pc, input logic [1:0] kind,
                          input logic [31:0] cond, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptg);
        ex_valid = v; ex_pc = pc; ex_kind = kind; ex_cond = cond;
        ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptg;
    endtask

    task automatic ex_idle();
        set_ex(1'b0, 32'h0, 2'b11, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic exp_pred(input logic t, input logic [31:0] tg);
        e_mask[3] = 1'b1; e_pt = t; e_ptg = tg;
    endtask

    task automatic exp_res(input logic mp, input logic [1:0] src, input logic [31:0] rd);
        e_mask[2] = 1'b1; e_mp = mp; e_src = src; e_rd = rd;
    endtask

    task automatic exp_fl(input logic f);
        e_mask[1] = 1'b1; e_fl = f;
    endtask

    task automatic exp_cnt(input logic [31:0] b, input logic [31:0] m);
        e_mask[0] = 1'b1; e_br = b; e_mpc = m;
    endtask

    task automatic tick();
        exp_q.push_back({e_mask, e_pt, e_ptg, e_mp, e_rd, e_src, e_fl, e_br, e_mpc});
        id_q.push_back(step_id);
        step_id++;
        e_mask = 4'b0000;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ex_idle();
        exp_res(1'b0, 2'b11, 32'h0); exp_fl(1'b0); exp_cnt(0, 0);
        tick();
        reset = 1'b0;
    endtask

    task automatic cmp(input string name, input int id, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL step %0d %s got %0h want %0h", id, name, got, want);
        end
    endtask

    logic [EW-1:0] m_e;
    int            m_id;
    logic [3:0]    m_mask;
    logic          m_pt, m_mp, m_fl;
    logic [31:0]   m_ptg, m_rd, m_br, m_mpc;
    logic [1:0]    m_src;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_e  = exp_q.pop_front();
            m_id = id_q.pop_front();
            {m_mask, m_pt, m_ptg, m_mp, m_rd, m_src, m_fl, m_br, m_mpc} = m_e;
            if (m_mask[3]) begin
                cmp("pred_taken", m_id, {31'h0, pred_taken}, {31'h0, m_pt});
                cmp("pred_target", m_id, pred_target, m_ptg);
            end
            if (m_mask[2]) begin
                cmp("mispredict", m_id, {31'h0, mispredict}, {31'h0, m_mp});
                cmp("pc_src", m_id, {30'h0, pc_src}, {30'h0, m_src});
                if (m_mp) cmp("redirect_pc", m_id, redirect_pc, m_rd);
            end
            if (m_mask[1]) cmp("flush", m_id, {31'h0, flush}, {31'h0, m_fl});
            if (m_mask[0]) begin
                cmp("br_count", m_id, br_count, m_br);
                cmp("mp_count", m_id, mp_count, m_mpc);
            end
        end
    end

    logic [31:0] r_pc, r_tgt, r_cond, r_ptg, m_brc, m_mpcnt;
    logic [1:0]  r_kind;
    logic        r_v, r_ptk, r_taken, r_live, r_mp;
    int          m_flc;

    initial begin
        e_mask = 4'b0000;
        reset  = 1'b1;
        if_pc  = 32'h100;
        set_ex(1'b1, 32'h100, 2'b10, 32'h1, 32'h200, 1'b0, 32'h104);
        @(posedge clk);
        #1;
        // Reset held with mispredicting EX inputs
        exp_pred(1'b0, 32'h104); exp_res(1'b0, 2'b11, 32'h0); exp_fl(1'b0); exp_cnt(0, 0); tick();
        exp_pred(1'b0, 32'h104); exp_res(1'b0, 2'b11, 32'h0); exp_fl(1'b0); exp_cnt(0, 0); tick();
        reset = 1'b0;
        ex_idle();

        // BEQ allocation and flush length
        exp_pred(0, 32'h104); exp_res(0, 2'b11, 0); exp_fl(0); exp_cnt(0, 0); tick();
        set_ex(1, 32'h100, 2'b10, 1, 32'h200, 0, 32'h104);
        exp_pred(0, 32'h104); exp_res(1, 2'b10, 32'h200); exp_fl(0); exp_cnt(0, 0); tick();
        ex_idle();
        exp_pred(1, 32'h200); exp_res(0, 2'b11, 0); exp_fl(1); exp_cnt(1, 1); tick();
        exp_pred(1, 32'h200); exp_fl(1); tick();
        exp_pred(1, 32'h200); exp_fl(0); exp_cnt(1, 1); tick();

        // Counter walks down and saturates at 00
        set_ex(1, 32'h100, 2'b10, 0, 32'h200, 0, 32'h104);
        exp_pred(1, 32'h200); exp_res(0, 2'b11, 0); exp_cnt(1, 1); tick();
        ex_idle();
        exp_pred(0, 32'h104); exp_fl(0); exp_cnt(2, 1); tick();
        set_ex(1, 32'h100, 2'b10, 0, 32'h200, 1, 32'h200);
        exp_pred(0, 32'h104); exp_res(1, 2'b11, 32'h104); exp_cnt(2, 1); tick();
        ex_idle();
        exp_pred(0, 32'h104); exp_fl(1); exp_cnt(3, 2); tick();
        exp_fl(1); tick();
        set_ex(1, 32'h100, 2'b10, 0, 32'h200, 0, 32'h104);
        exp_pred(0, 32'h104); exp_res(0, 2'b11, 0); exp_fl(0); exp_cnt(3, 2); tick();
        set_ex(1, 32'h100, 2'b10, 5, 32'h200, 0, 32'h104);
        exp_res(1, 2'b10, 32'h200); exp_cnt(4, 2); tick();
        ex_idle();
        exp_pred(0, 32'h104); exp_fl(1); exp_cnt(5, 3); tick();
        exp_fl(1); tick();
        exp_pred(0, 32'h104); exp_fl(0); tick();

        // JR target retraining, then J
        do_reset();
        if_pc = 32'h40;
        set_ex(1, 32'h40, 2'b00, 0, 32'h500, 0, 32'h44);
        exp_pred(0, 32'h44); exp_res(1, 2'b00, 32'h500); exp_cnt(0, 0); tick();
        ex_idle();
        exp_pred(1, 32'h500); exp_fl(1); exp_cnt(1, 1); tick();
        exp_pred(1, 32'h500); exp_fl(1); tick();
        set_ex(1, 32'h40, 2'b00, 0, 32'h600, 1, 32'h500);
        exp_pred(1, 32'h500); exp_res(1, 2'b00, 32'h600); exp_fl(0); tick();
        ex_idle();
        exp_pred(1, 32'h600); exp_fl(1); exp_cnt(2, 2); tick();
        exp_fl(1); tick();
        set_ex(1, 32'h40, 2'b00, 0, 32'h600, 1, 32'h600);
        exp_res(0, 2'b11, 0); exp_fl(0); exp_cnt(2, 2); tick();
        if_pc = 32'h104;
        set_ex(1, 32'h104, 2'b01, 0, 32'h800, 0, 32'h108);
        exp_pred(0, 32'h108); exp_res(1, 2'b01, 32'h800); exp_cnt(3, 2); tick();
        ex_idle();
        exp_pred(1, 32'h800); exp_fl(1); exp_cnt(4, 3); tick();
        exp_fl(1); tick();
        if_pc = 32'h40;
        exp_pred(1, 32'h600); exp_fl(0); exp_cnt(4, 3); tick();

        // Non-branch hitting an entry removes the alias
        set_ex(1, 32'h40, 2'b11, 0, 32'h0, 1, 32'h600);
        exp_pred(1, 32'h600); exp_res(1, 2'b11, 32'h44); exp_cnt(4, 3); tick();
        ex_idle();
        exp_pred(0, 32'h44); exp_fl(1); exp_cnt(4, 4); tick();
        exp_fl(1); tick();
        if_pc = 32'h104;
        exp_pred(1, 32'h800); exp_fl(0); exp_cnt(4, 4); tick();
        set_ex(1, 32'h200, 2'b11, 0, 32'h0, 0, 32'h204);
        exp_res(0, 2'b11, 0); exp_cnt(4, 4); tick();
        ex_idle();
        exp_cnt(4, 4); tick();

        // EX ignored during flush, eviction, reset mid-flush
        if_pc = 32'h10;
        set_ex(1, 32'h10, 2'b10, 1, 32'h300, 0, 32'h14);
        exp_pred(0, 32'h14); exp_res(1, 2'b10, 32'h300); exp_cnt(4, 4); tick();
        set_ex(1, 32'h20, 2'b01, 0, 32'h900, 0, 32'h24);
        exp_pred(1, 32'h300); exp_res(0, 2'b11, 0); exp_fl(1); exp_cnt(5, 5); tick();
        if_pc = 32'h20;
        set_ex(1, 32'h10, 2'b10, 0, 32'h300, 1, 32'h300);
        exp_pred(0, 32'h24); exp_res(0, 2'b11, 0); exp_fl(1); exp_cnt(5, 5); tick();
        ex_idle();
        if_pc = 32'h10;
        exp_pred(1, 32'h300); exp_fl(0); exp_cnt(5, 5); tick();
        set_ex(1, 32'h20, 2'b01, 0, 32'h900, 0, 32'h24);
        exp_pred(1, 32'h300); exp_res(1, 2'b01, 32'h900); exp_cnt(5, 5); tick();
        ex_idle();
        exp_pred(0, 32'h14); exp_fl(1); exp_cnt(6, 6); tick();
        if_pc = 32'h20;
        exp_pred(1, 32'h900); exp_fl(1); tick();
        set_ex(1, 32'h10, 2'b10, 1, 32'h300, 0, 32'h14);
        exp_pred(1, 32'h900); exp_res(1, 2'b10, 32'h300); exp_fl(0); exp_cnt(6, 6); tick();
        reset = 1'b1;
        if_pc = 32'h10;
        set_ex(1, 32'h40, 2'b00, 0, 32'h700, 0, 32'h44);
        exp_pred(0, 32'h14); exp_res(0, 2'b11, 0); exp_fl(0); exp_cnt(0, 0); tick();
        exp_pred(0, 32'h14); exp_res(0, 2'b11, 0); exp_fl(0); exp_cnt(0, 0); tick();
        reset = 1'b0;
        ex_idle();
        exp_pred(0, 32'h14); exp_fl(0); exp_cnt(0, 0); tick();
        set_ex(1, 32'h10, 2'b10, 1, 32'h300, 0, 32'h14);
        exp_res(1, 2'b10, 32'h300); exp_fl(0); tick();
        ex_idle();
        exp_pred(1, 32'h300); exp_fl(1); exp_cnt(1, 1); tick();
        exp_fl(1); tick();
        exp_fl(0); exp_cnt(1, 1); tick();

        // Counter saturates at 11
        if_pc = 32'h104;
        set_ex(1, 32'h104, 2'b10, 1, 32'h400, 0, 32'h108);
        exp_pred(0, 32'h108); exp_res(1, 2'b10, 32'h400); exp_cnt(1, 1); tick();
        ex_idle();
        exp_pred(1, 32'h400); exp_fl(1); exp_cnt(2, 2); tick();
        exp_fl(1); tick();
        set_ex(1, 32'h104, 2'b10, 1, 32'h400, 1, 32'h400);
        exp_res(0, 2'b11, 0); exp_fl(0); exp_cnt(2, 2); tick();
        exp_res(0, 2'b11, 0); exp_cnt(3, 2); tick();
        set_ex(1, 32'h104, 2'b10, 0, 32'h400, 1, 32'h400);
        exp_res(1, 2'b11, 32'h108); exp_cnt(4, 2); tick();
        ex_idle();
        exp_pred(1, 32'h400); exp_fl(1); exp_cnt(5, 3); tick();
        exp_fl(1); tick();
        exp_pred(1, 32'h400); exp_fl(0); exp_cnt(5, 3); tick();

        // Random branches against a counter/flush model
        m_brc = 5; m_mpcnt = 3; m_flc = 0;
        for (int i = 0; i < 1000; i++) begin
            r_v    = ($urandom_range(0, 3) != 0);
            r_kind = 2'($urandom_range(0, 3));
            r_pc   = 32'($urandom_range(0, 255)) << 2;
            r_cond = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(1, 1000)) : 32'h0;
            r_tgt  = 32'($urandom_range(0, 63)) << 4;
            r_ptk  = ($urandom_range(0, 1) != 0);
            r_ptg  = ($urandom_range(0, 1) != 0) ? r_tgt : r_pc + 32'd4;
            case (r_kind)
                2'b00, 2'b01: r_taken = 1'b1;
                2'b10:        r_taken = (r_cond != 0);
                default:      r_taken = 1'b0;
            endcase
            r_live = r_v && (m_flc == 0);
            r_mp   = r_live && ((r_taken != r_ptk) || (r_taken && (r_tgt != r_ptg)));
            if_pc  = r_pc;
            set_ex(r_v, r_pc, r_kind, r_cond, r_tgt, r_ptk, r_ptg);
            exp_res(r_mp, (r_mp && r_taken) ? r_kind : 2'b11, r_taken ? r_tgt : r_pc + 32'd4);
            exp_fl(m_flc != 0);
            exp_cnt(m_brc, m_mpcnt);
            tick();
            if (r_live && (r_kind != 2'b11)) m_brc++;
            if (r_mp) m_mpcnt++;
            if (m_flc > 0) m_flc--;
            else if (r_mp) m_flc = 2;
        end
        ex_idle();
        exp_fl(m_flc != 0); exp_cnt(m_brc, m_mpcnt); tick();

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
